// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: FSM state encodings and frame-format constants shared by the loader
package imem_loader_pkg;
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LEN_LO = 3'd1;
   localparam logic [2:0] ST_LEN_HI = 3'd2;
   localparam logic [2:0] ST_DATA   = 3'd3;
   localparam logic [2:0] ST_WR     = 3'd4;
   localparam logic [2:0] ST_CSUM   = 3'd5;
   localparam logic [2:0] ST_DONE   = 3'd6;
   localparam logic [2:0] ST_ERR    = 3'd7;
   localparam logic [7:0] SYNC_DEFAULT   = 8'hA5;
   localparam int         BYTES_PER_WORD = 4;
   localparam int         LEN_W          = 16;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake plus instruction-memory write port
interface imem_loader_if #(parameter int ADDR_W = 10) ();
   logic              rx_valid;
   logic [7:0]        rx_data;
   logic              rx_ready;
   logic              imem_wen;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   modport master (output rx_valid, rx_data, input rx_ready, imem_wen, imem_addr, imem_wdata);
   modport slave  (input rx_valid, rx_data, output rx_ready, imem_wen, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_loader.sv
// imem_loader: unpacks a framed byte stream into instruction memory and gates CPU reset
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int         ADDR_W = 10,
   parameter int         DEPTH  = 1024,
   parameter logic [7:0] SYNC   = SYNC_DEFAULT
) (
   input  logic         clk,
   input  logic         reset_n,
   imem_loader_if.slave bus,
   output logic         cpu_reset_n,
   output logic         load_done,
   output logic         load_err
);
   localparam int CNT_W = $clog2(DEPTH + 1);
   logic [2:0]       state;
   logic [1:0]       byte_cnt;
   logic [CNT_W-1:0] word_cnt, n_words;
   logic [7:0]       len_lo, csum;
   logic [23:0]      shreg;
   logic [LEN_W-1:0] len;
   logic             xfer, is_sync, len_bad;
   assign xfer    = bus.rx_valid & bus.rx_ready;
   assign is_sync = xfer && bus.rx_data == SYNC;
   assign len     = {bus.rx_data, len_lo};
   assign len_bad = len == '0 || 32'(len) > 32'(DEPTH);
   // frame FSM; every output is a flop so downstream sees glitch-free strobes
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= ST_IDLE;
         byte_cnt       <= '0;
         word_cnt       <= '0;
         n_words        <= '0;
         len_lo         <= '0;
         csum           <= '0;
         shreg          <= '0;
         bus.rx_ready   <= 1'b1;
         bus.imem_wen   <= 1'b0;
         bus.imem_addr  <= '0;
         bus.imem_wdata <= '0;
         cpu_reset_n    <= 1'b0;
         load_done      <= 1'b0;
         load_err       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (state == ST_DONE) cpu_reset_n <= 1'b1;
               if (is_sync) begin
                  state       <= ST_LEN_LO;
                  csum        <= '0;
                  byte_cnt    <= '0;
                  word_cnt    <= '0;
                  cpu_reset_n <= 1'b0;
                  load_done   <= 1'b0;
                  load_err    <= 1'b0;
               end
            end
            ST_LEN_LO: if (xfer) begin
               len_lo <= bus.rx_data;
               csum   <= csum + bus.rx_data;
               state  <= ST_LEN_HI;
            end
            ST_LEN_HI: if (xfer) begin
               csum     <= csum + bus.rx_data;
               n_words  <= CNT_W'(len);
               state    <= len_bad ? ST_ERR : ST_DATA;
               load_err <= len_bad;
            end
            ST_DATA: if (xfer) begin
               csum     <= csum + bus.rx_data;
               byte_cnt <= byte_cnt + 2'd1;
               shreg    <= {bus.rx_data, shreg[23:8]};
               if (byte_cnt == 2'(BYTES_PER_WORD - 1)) begin
                  state          <= ST_WR;
                  bus.imem_wen   <= 1'b1;
                  bus.imem_addr  <= ADDR_W'(word_cnt);
                  bus.imem_wdata <= {bus.rx_data, shreg};
                  bus.rx_ready   <= 1'b0;
               end
            end
            ST_WR: begin
               bus.imem_wen <= 1'b0;
               bus.rx_ready <= 1'b1;
               word_cnt     <= word_cnt + CNT_W'(1);
               state        <= (word_cnt + CNT_W'(1) == n_words) ? ST_CSUM : ST_DATA;
            end
            ST_CSUM: if (xfer) begin
               state     <= (bus.rx_data == csum) ? ST_DONE : ST_ERR;
               load_done <= bus.rx_data == csum;
               load_err  <= bus.rx_data != csum;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
